cpu_controller: RTL and testbench

Control FSM and instruction decoder that drives the 16-bit datapath's control inputs. It sequences fetch from unified memory, latches the instruction register (IR), and decodes it. It then issues per-cycle register-file, ALU, status and memory controls for MOV, ADD, CMP, AND, MVN, LDR, STR and HALT. Sits between the memory interface and the datapath; the PC and address registers are external and driven by its load/select outputs.

---
 rtl/cpu_controller_if.sv | 39 +++
 rtl/cpu_controller.sv | 165 ++++++++++++++++
 tb/tb_cpu_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_controller_if.sv
// Control bundle between the controller and the 16-bit datapath/memory.
// master = controller side (drives controls, samples mdata); slave = datapath side.
interface cpu_controller_if;
    logic [15:0] mdata;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic        loadc;
    logic        loads;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic [1:0]  mem_cmd;
    logic        addr_sel;
    logic        load_pc;
    logic        reset_pc;
    logic        load_addr;
    logic        halted;

    modport master (
        input  mdata,
        output readnum, writenum, write, vsel, loada, loadb, asel, bsel,
               shift, ALUop, loadc, loads, sximm5, sximm8, mem_cmd,
               addr_sel, load_pc, reset_pc, load_addr, halted
    );

    modport slave (
        output mdata,
        input  readnum, writenum, write, vsel, loada, loadb, asel, bsel,
               shift, ALUop, loadc, loads, sximm5, sximm8, mem_cmd,
               addr_sel, load_pc, reset_pc, load_addr, halted
    );
endinterface

// File: rtl/cpu_controller.sv
// Moore control FSM + decoder for the 16-bit datapath: 5..10 cycles per instruction.
// No backpressure: memory is assumed to answer in the cycle mem_cmd is held.
module cpu_controller (
    input  logic              clk,
    input  logic              reset_n,
    cpu_controller_if.master  bus
);
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_WR_IMM,
        S_GET_A, S_GET_B, S_EXEC, S_WR_RD, S_ADDR, S_LD_ADDR,
        S_MEM_RD, S_WR_MEM, S_GET_RD, S_PASS_RD, S_MEM_WR, S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_ir;

    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [4:0] w_opx;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_opx    = r_ir[15:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_sh     = r_ir[4:3];
    assign w_rm     = r_ir[2:0];

    assign bus.sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};
    assign bus.sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_RST;
            r_ir    <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IF2)
                r_ir <= bus.mdata;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RST:       w_next_state = S_IF1;
            S_IF1:       w_next_state = S_IF2;
            S_IF2:       w_next_state = S_UPDATE_PC;
            S_UPDATE_PC: w_next_state = S_DECODE;
            S_DECODE: begin
                case (w_opx)
                    5'b11010:                   w_next_state = S_WR_IMM;
                    5'b11000, 5'b10111:         w_next_state = S_GET_B;
                    5'b10100, 5'b10101, 5'b10110,
                    5'b01100, 5'b10000:         w_next_state = S_GET_A;
                    default:                    w_next_state = S_HALT;
                endcase
            end
            S_WR_IMM:    w_next_state = S_IF1;
            S_GET_A:     w_next_state = (w_opcode == 3'b011 || w_opcode == 3'b100) ? S_ADDR : S_GET_B;
            S_GET_B:     w_next_state = S_EXEC;
            S_EXEC:      w_next_state = (w_opx == 5'b10101) ? S_IF1 : S_WR_RD;
            S_WR_RD:     w_next_state = S_IF1;
            S_ADDR:      w_next_state = S_LD_ADDR;
            S_LD_ADDR:   w_next_state = (w_opcode == 3'b011) ? S_MEM_RD : S_GET_RD;
            S_MEM_RD:    w_next_state = S_WR_MEM;
            S_WR_MEM:    w_next_state = S_IF1;
            S_GET_RD:    w_next_state = S_PASS_RD;
            S_PASS_RD:   w_next_state = S_MEM_WR;
            S_MEM_WR:    w_next_state = S_IF1;
            S_HALT:      w_next_state = S_HALT;
            default:     w_next_state = S_RST;
        endcase
    end

    always_comb begin
        bus.readnum   = 3'd0;
        bus.writenum  = 3'd0;
        bus.write     = 1'b0;
        bus.vsel      = 2'b00;
        bus.loada     = 1'b0;
        bus.loadb     = 1'b0;
        bus.asel      = 1'b0;
        bus.bsel      = 1'b0;
        bus.shift     = 2'b00;
        bus.ALUop     = 2'b00;
        bus.loadc     = 1'b0;
        bus.loads     = 1'b0;
        bus.mem_cmd   = MNONE;
        bus.addr_sel  = 1'b0;
        bus.load_pc   = 1'b0;
        bus.reset_pc  = 1'b0;
        bus.load_addr = 1'b0;
        bus.halted    = 1'b0;
        case (r_state)
            S_RST: begin
                bus.reset_pc = 1'b1;
                bus.load_pc  = 1'b1;
            end
            S_IF1, S_IF2: begin
                bus.addr_sel = 1'b1;
                bus.mem_cmd  = MREAD;
            end
            S_UPDATE_PC: bus.load_pc = 1'b1;
            S_WR_IMM: begin
                bus.writenum = w_rn;
                bus.vsel     = 2'b10;
                bus.write    = 1'b1;
            end
            S_GET_A: begin
                bus.readnum = w_rn;
                bus.loada   = 1'b1;
            end
            S_GET_B: begin
                bus.readnum = w_rm;
                bus.loadb   = 1'b1;
            end
            S_EXEC: begin
                bus.shift = w_sh;
                case (w_opx)
                    5'b11000: begin bus.asel = 1'b1; bus.ALUop = 2'b00; bus.loadc = 1'b1; end
                    5'b10111: begin bus.asel = 1'b1; bus.ALUop = 2'b11; bus.loadc = 1'b1; end
                    5'b10101: begin bus.ALUop = 2'b01; bus.loads = 1'b1; end
                    default:  begin bus.ALUop = w_op; bus.loadc = 1'b1; end
                endcase
            end
            S_WR_RD: begin
                bus.writenum = w_rd;
                bus.write    = 1'b1;
            end
            S_ADDR: begin
                bus.bsel  = 1'b1;
                bus.loadc = 1'b1;
            end
            S_LD_ADDR: bus.load_addr = 1'b1;
            S_MEM_RD:  bus.mem_cmd   = MREAD;
            S_WR_MEM: begin
                bus.mem_cmd  = MREAD;
                bus.vsel     = 2'b11;
                bus.writenum = w_rd;
                bus.write    = 1'b1;
            end
            S_GET_RD: begin
                bus.readnum = w_rd;
                bus.loadb   = 1'b1;
            end
            S_PASS_RD: begin
                bus.asel  = 1'b1;
                bus.loadc = 1'b1;
            end
            S_MEM_WR: bus.mem_cmd = MWRITE;
            S_HALT:   bus.halted  = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cpu_controller.sv
// Random instruction stream checked cycle by cycle against a per-instruction control-sequence model.
module tb_cpu_controller;
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef struct packed {
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       loadc;
        logic       loads;
        logic [1:0] mem_cmd;
        logic       addr_sel;
        logic       load_pc;
        logic       reset_pc;
        logic       load_addr;
        logic       halted;
    } ctl_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;
    ctl_t exp_q[$];
    logic [15:0] prev_ir;

    cpu_controller_if bus();

    cpu_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ctl_t observe();
        ctl_t c;
        c.readnum   = bus.readnum;
        c.writenum  = bus.writenum;
        c.write     = bus.write;
        c.vsel      = bus.vsel;
        c.loada     = bus.loada;
        c.loadb     = bus.loadb;
        c.asel      = bus.asel;
        c.bsel      = bus.bsel;
        c.shift     = bus.shift;
        c.aluop     = bus.ALUop;
        c.loadc     = bus.loadc;
        c.loads     = bus.loads;
        c.mem_cmd   = bus.mem_cmd;
        c.addr_sel  = bus.addr_sel;
        c.load_pc   = bus.load_pc;
        c.reset_pc  = bus.reset_pc;
        c.load_addr = bus.load_addr;
        c.halted    = bus.halted;
        return c;
    endfunction

    function automatic logic [15:0] sext(input logic [15:0] ins, input int bits);
        int v;
        v = int'(ins) & ((1 << bits) - 1);
        if (v >= (1 << (bits - 1))) v -= (1 << bits);
        return v[15:0];
    endfunction

    function automatic ctl_t rst_vec();
        ctl_t c = '0;
        c.reset_pc = 1'b1;
        c.load_pc  = 1'b1;
        return c;
    endfunction

    // Expected per-cycle controls for one instruction, from IF1 up to (not including) the next IF1.
    task automatic build(input logic [15:0] ins, output bit hlt);
        ctl_t c;
        logic [2:0] rn, rd, rm;
        logic [1:0] sh, op;
        rn = ins[10:8]; rd = ins[7:5]; sh = ins[4:3]; rm = ins[2:0]; op = ins[12:11];
        exp_q.delete();
        hlt = 1'b0;
        c = '0; c.addr_sel = 1; c.mem_cmd = MREAD;
        exp_q.push_back(c); exp_q.push_back(c);
        c = '0; c.load_pc = 1; exp_q.push_back(c);
        c = '0; exp_q.push_back(c);
        case (ins[15:11])
            5'b11010: begin // MOV imm
                c = '0; c.writenum = rn; c.vsel = 2'b10; c.write = 1; exp_q.push_back(c);
            end
            5'b11000, 5'b10111, 5'b10100, 5'b10110, 5'b10101: begin
                if (ins[15:13] == 3'b101 && op != 2'b11) begin
                    c = '0; c.readnum = rn; c.loada = 1; exp_q.push_back(c);
                end
                c = '0; c.readnum = rm; c.loadb = 1; exp_q.push_back(c);
                c = '0; c.shift = sh;
                if (ins[15:11] == 5'b11000) begin c.asel = 1; c.aluop = 2'b00; c.loadc = 1; end
                else if (ins[15:11] == 5'b10111) begin c.asel = 1; c.aluop = 2'b11; c.loadc = 1; end
                else if (ins[15:11] == 5'b10101) begin c.aluop = 2'b01; c.loads = 1; end
                else begin c.aluop = op; c.loadc = 1; end
                exp_q.push_back(c);
                if (ins[15:11] != 5'b10101) begin
                    c = '0; c.writenum = rd; c.write = 1; exp_q.push_back(c);
                end
            end
            5'b01100, 5'b10000: begin // LDR / STR
                c = '0; c.readnum = rn; c.loada = 1; exp_q.push_back(c);
                c = '0; c.bsel = 1; c.loadc = 1; exp_q.push_back(c);
                c = '0; c.load_addr = 1; exp_q.push_back(c);
                if (ins[15:13] == 3'b011) begin
                    c = '0; c.mem_cmd = MREAD; exp_q.push_back(c);
                    c.vsel = 2'b11; c.writenum = rd; c.write = 1; exp_q.push_back(c);
                end else begin
                    c = '0; c.readnum = rd; c.loadb = 1; exp_q.push_back(c);
                    c = '0; c.asel = 1; c.loadc = 1; exp_q.push_back(c);
                    c = '0; c.mem_cmd = MWRITE; exp_q.push_back(c);
                end
            end
            default: hlt = 1'b1;
        endcase
    endtask

    task automatic check_cycle(input logic [15:0] ins, input int k, input ctl_t e, input logic [15:0] ir_e);
        ctl_t o;
        o = observe();
        check_val($sformatf("ctl ins=%h cyc%0d", ins, k), 32'(o), 32'(e));
        check_val($sformatf("sximm5 ins=%h cyc%0d", ins, k), 32'(bus.sximm5), 32'(sext(ir_e, 5)));
        check_val($sformatf("sximm8 ins=%h cyc%0d", ins, k), 32'(bus.sximm8), 32'(sext(ir_e, 8)));
    endtask

    // Entered and left at posedge+1 with the DUT in IF1; stop_at>=0 asserts reset at that cycle.
    task automatic run_instr(input logic [15:0] ins, input int stop_at);
        bit hlt;
        ctl_t h;
        build(ins, hlt);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < 2) bus.mdata = ins;
            check_cycle(ins, k, exp_q[k], (k < 2) ? prev_ir : ins);
            if (k >= 2) bus.mdata = 16'($urandom);
            if (k == stop_at) begin
                reset_n = 1'b0;
                #1;
                check_cycle(ins, 100, rst_vec(), 16'h0000);
                reset_release();
                return;
            end
            @(posedge clk); #1;
        end
        prev_ir = ins;
        if (hlt) begin
            h = '0; h.halted = 1'b1;
            for (int k = 0; k < 22; k++) begin
                bus.mdata = 16'($urandom);
                check_cycle(ins, 200 + k, h, ins);
                @(posedge clk); #1;
            end
            reset_n = 1'b0;
            #1;
            check_cycle(ins, 300, rst_vec(), 16'h0000);
            reset_release();
        end
    endtask

    // Holds reset a few cycles (never a write), releases it, and lands in IF1 at posedge+1.
    task automatic reset_release();
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_cycle(16'h0000, 400 + k, rst_vec(), 16'h0000);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_cycle(16'h0000, 410, rst_vec(), 16'h0000);
        @(posedge clk); #1;
        prev_ir = 16'h0000;
    endtask

    logic [4:0] legal [8];
    logic [15:0] ins;

    initial begin
        legal[0] = 5'b11010; legal[1] = 5'b11000; legal[2] = 5'b10100; legal[3] = 5'b10101;
        legal[4] = 5'b10110; legal[5] = 5'b10111; legal[6] = 5'b01100; legal[7] = 5'b10000;
        bus.mdata = 16'h0000;
        prev_ir   = 16'h0000;
        reset_n   = 1'b0;
        #1;
        reset_release();

        run_instr(16'hD1F6, -1);
        run_instr(16'hA2A8, -1);
        run_instr(16'hAB01, -1);
        run_instr(16'h6245, -1);
        run_instr(16'h8460, -1);
        for (int i = 0; i < 250; i++) begin
            ins = 16'($urandom);
            ins[15:11] = legal[$urandom_range(0, 7)];
            run_instr(ins, -1);
        end
        run_instr(16'h8460, 7);
        run_instr(16'hA2A8, -1);
        run_instr(16'hE000, -1);
        run_instr(16'hD1F6, -1);
        run_instr(16'h2ABC, -1);
        run_instr(16'hAB01, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
